// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - one requester port of the memory arbiter
interface mem_port_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              req;
   logic              we;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] wdata;
   logic              ack;
   logic [DATA_W-1:0] rdata;

   // Requester side: holds req/we/addr/wdata level until it sees ack
   modport master (
      output req, we, addr, wdata,
      input  ack, rdata
   );

   // Arbiter side
   modport slave (
      input  req, we, addr, wdata,
      output ack, rdata
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - two-port round-robin arbiter in front of a single-port memory
module mem_port_arbiter #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int MEM_LAT = 1
) (
   input  logic              clock,
   input  logic              reset,
   mem_port_arbiter_if.slave port0,
   mem_port_arbiter_if.slave port1,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_wr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy,
   output logic              owner
);

   // cnt only ever counts down from MEM_LAT-1, so it never needs to hold MEM_LAT+1
   localparam int CNT_W = (MEM_LAT < 1) ? 1 : $clog2(MEM_LAT + 1);

   if (MEM_LAT < 1) begin : g_bad_mem_lat
      $error("mem_port_arbiter: MEM_LAT must be >= 1");
   end

   typedef enum logic [1:0] {
      S_IDLE,
      S_ACCESS,
      S_DONE
   } state_t;

   state_t            state;
   logic [CNT_W-1:0]  cnt;
   logic              lat_we;
   logic              last_served;
   logic              ack0;
   logic              ack1;
   logic [DATA_W-1:0] rdata0;
   logic [DATA_W-1:0] rdata1;
   logic              win;

   // A lone request wins outright; on a tie the port not served last wins
   assign win = (port0.req && port1.req) ? ~last_served : port1.req;

   assign port0.ack   = ack0;
   assign port1.ack   = ack1;
   assign port0.rdata = rdata0;
   assign port1.rdata = rdata1;

   // Grant / access / complete sequencer; all outputs are registered here
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state       <= S_IDLE;
         cnt         <= '0;
         lat_we      <= 1'b0;
         last_served <= 1'b1;
         owner       <= 1'b0;
         mem_addr    <= '0;
         mem_wdata   <= '0;
         mem_wr      <= 1'b0;
         busy        <= 1'b0;
         ack0        <= 1'b0;
         ack1        <= 1'b0;
         rdata0      <= '0;
         rdata1      <= '0;
      end else begin
         // acks and the write strobe are single-cycle pulses
         ack0   <= 1'b0;
         ack1   <= 1'b0;
         mem_wr <= 1'b0;
         case (state)
            S_IDLE: begin
               if (port0.req || port1.req) begin
                  owner     <= win;
                  mem_addr  <= win ? port1.addr  : port0.addr;
                  mem_wdata <= win ? port1.wdata : port0.wdata;
                  lat_we    <= win ? port1.we    : port0.we;
                  mem_wr    <= win ? port1.we    : port0.we;
                  cnt       <= CNT_W'(MEM_LAT - 1);
                  busy      <= 1'b1;
                  state     <= S_ACCESS;
               end
            end
            S_ACCESS: begin
               if (cnt != '0) begin
                  cnt <= cnt - CNT_W'(1);
               end else begin
                  if (!lat_we) begin
                     if (owner) rdata1 <= mem_rdata;
                     else       rdata0 <= mem_rdata;
                  end
                  if (owner) ack1 <= 1'b1;
                  else       ack0 <= 1'b1;
                  last_served <= owner;
                  state       <= S_DONE;
               end
            end
            S_DONE: begin
               // requests are ignored here; the requester updates req on this edge
               busy  <= 1'b0;
               state <= S_IDLE;
            end
            default: begin
               busy  <= 1'b0;
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench, MEM_LAT=1 and MEM_LAT=3 instances
module tb_mem_port_arbiter;

   logic clock;
   logic reset;

   int vectors     = 0;
   int miscompares = 0;

   // stimulus and observation arrays, [instance][port]
   logic        t_req   [2][2];
   logic        t_we    [2][2];
   logic [31:0] t_addr  [2][2];
   logic [31:0] t_wdata [2][2];
   logic        t_ack   [2][2];
   logic [31:0] t_rdata [2][2];
   logic [31:0] t_mem_addr  [2];
   logic        t_mem_wr    [2];
   logic [31:0] t_mem_wdata [2];
   logic [31:0] t_mem_rdata [2];
   logic        t_busy      [2];
   logic        t_owner     [2];

   int lat_of [2] = '{1, 3};

   // memory contents as a pure function of the address
   function automatic logic [31:0] memf(input logic [31:0] a);
      if (a == 32'h10) return 32'hDEADBEEF;
      return (a * 32'h9E3779B1) ^ 32'h5A5A0000;
   endfunction

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   for (genvar g = 0; g < 2; g++) begin : cfg
      mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) port0 ();
      mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) port1 ();

      assign port0.req   = t_req[g][0];
      assign port0.we    = t_we[g][0];
      assign port0.addr  = t_addr[g][0];
      assign port0.wdata = t_wdata[g][0];
      assign port1.req   = t_req[g][1];
      assign port1.we    = t_we[g][1];
      assign port1.addr  = t_addr[g][1];
      assign port1.wdata = t_wdata[g][1];
      assign t_ack[g][0]   = port0.ack;
      assign t_ack[g][1]   = port1.ack;
      assign t_rdata[g][0] = port0.rdata;
      assign t_rdata[g][1] = port1.rdata;
      assign t_mem_rdata[g] = memf(t_mem_addr[g]);

      mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(g == 0 ? 1 : 3)) dut (
         .clock     (clock),
         .reset     (reset),
         .port0     (port0),
         .port1     (port1),
         .mem_addr  (t_mem_addr[g]),
         .mem_wr    (t_mem_wr[g]),
         .mem_wdata (t_mem_wdata[g]),
         .mem_rdata (t_mem_rdata[g]),
         .busy      (t_busy[g]),
         .owner     (t_owner[g])
      );
   end

   task automatic chk_b(input string nm, input int g, input logic act, input logic exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s inst%0d: got %b, expected %b (t=%0t)", nm, g, act, exp, $time);
      end
   endtask

   task automatic chk_w(input string nm, input int g, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s inst%0d: got %h, expected %h (t=%0t)", nm, g, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // phase = cycles since the grant edge (0 = idle); 1..LAT are memory cycles,
   // LAT+1 is the completion cycle, after which the arbiter is free again.
   int          m_phase [2];
   logic        m_own   [2];
   logic        m_last  [2];
   logic        m_we    [2];
   logic [31:0] m_maddr [2];
   logic [31:0] m_mwdat [2];
   logic [31:0] m_rd    [2][2];

   function automatic logic pick(input logic r0, input logic r1, input logic last);
      return (r0 && r1) ? !last : r1;
   endfunction

   always @(posedge clock or negedge reset) begin
      for (int g = 0; g < 2; g++) begin
         if (!reset) begin
            m_phase[g]  <= 0;
            m_own[g]    <= 1'b0;
            m_last[g]   <= 1'b1;
            m_we[g]     <= 1'b0;
            m_maddr[g]  <= '0;
            m_mwdat[g]  <= '0;
            m_rd[g][0]  <= '0;
            m_rd[g][1]  <= '0;
         end else if (m_phase[g] == 0) begin
            if (t_req[g][0] || t_req[g][1]) begin
               m_own[g]   <= pick(t_req[g][0], t_req[g][1], m_last[g]);
               m_maddr[g] <= t_addr[g][pick(t_req[g][0], t_req[g][1], m_last[g])];
               m_mwdat[g] <= t_wdata[g][pick(t_req[g][0], t_req[g][1], m_last[g])];
               m_we[g]    <= t_we[g][pick(t_req[g][0], t_req[g][1], m_last[g])];
               m_phase[g] <= 1;
            end
         end else if (m_phase[g] <= lat_of[g]) begin
            if (m_phase[g] == lat_of[g]) begin
               if (!m_we[g]) m_rd[g][m_own[g]] <= memf(m_maddr[g]);
               m_last[g] <= m_own[g];
            end
            m_phase[g] <= m_phase[g] + 1;
         end else begin
            m_phase[g] <= 0;
         end
      end
   end

   // compare every output of both instances on each falling edge
   always @(negedge clock) begin
      for (int g = 0; g < 2; g++) begin
         chk_b("busy",      g, t_busy[g],     m_phase[g] != 0);
         chk_b("mem_wr",    g, t_mem_wr[g],   m_phase[g] == 1 && m_we[g]);
         chk_b("ack0",      g, t_ack[g][0],   m_phase[g] == lat_of[g] + 1 && m_own[g] == 1'b0);
         chk_b("ack1",      g, t_ack[g][1],   m_phase[g] == lat_of[g] + 1 && m_own[g] == 1'b1);
         chk_b("owner",     g, t_owner[g],    m_own[g]);
         chk_w("mem_addr",  g, t_mem_addr[g], m_maddr[g]);
         chk_w("mem_wdata", g, t_mem_wdata[g], m_mwdat[g]);
         chk_w("rdata0",    g, t_rdata[g][0], m_rd[g][0]);
         chk_w("rdata1",    g, t_rdata[g][1], m_rd[g][1]);
      end
   end

   // ---------------- stimulus ----------------
   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic new_txn(input int g, input int p);
      t_we[g][p]    = 1'($urandom_range(0, 1));
      t_addr[g][p]  = ($urandom_range(0, 7) == 0) ? 32'h10 : $urandom;
      t_wdata[g][p] = $urandom;
   endtask

   task automatic rand_drive();
      for (int g = 0; g < 2; g++) begin
         for (int p = 0; p < 2; p++) begin
            if (t_req[g][p]) begin
               if (t_ack[g][p]) begin
                  if ($urandom_range(0, 1) == 1) new_txn(g, p);
                  else t_req[g][p] = 1'b0;
               end
            end else begin
               new_txn(g, p);
               if ($urandom_range(0, 2) == 0) t_req[g][p] = 1'b1;
            end
         end
      end
   endtask

   int ord  [2][8];
   int at   [2][8];
   int nsv  [2];
   int nwr;
   int nack;
   int ack_c;

   initial begin
      reset = 1'b0;
      for (int g = 0; g < 2; g++) begin
         nsv[g] = 0;
         for (int p = 0; p < 2; p++) begin
            t_req[g][p]   = 1'b1;
            t_we[g][p]    = 1'b0;
            t_wdata[g][p] = '0;
         end
      end
      t_addr[0][0] = 32'h10;
      t_addr[0][1] = 32'h30;
      t_addr[1][0] = 32'h40;
      t_addr[1][1] = 32'h50;

      // reset held with both requests high: everything idle and zero
      repeat (3) step();
      for (int g = 0; g < 2; g++) begin
         chk_b("rst_busy",     g, t_busy[g],     1'b0);
         chk_b("rst_ack0",     g, t_ack[g][0],   1'b0);
         chk_b("rst_ack1",     g, t_ack[g][1],   1'b0);
         chk_b("rst_mem_wr",   g, t_mem_wr[g],   1'b0);
         chk_b("rst_owner",    g, t_owner[g],    1'b0);
         chk_w("rst_mem_addr", g, t_mem_addr[g], 32'h0);
         chk_w("rst_rdata0",   g, t_rdata[g][0], 32'h0);
      end
      reset = 1'b1;

      // continuous tie on both instances; single read details on the first grant
      for (int c = 1; c <= 12; c++) begin
         step();
         for (int g = 0; g < 2; g++) begin
            for (int p = 0; p < 2; p++) begin
               if (t_ack[g][p] && nsv[g] < 8) begin
                  ord[g][nsv[g]] = p;
                  at[g][nsv[g]]  = c;
                  nsv[g]++;
               end
            end
            chk_b("ack_overlap", g, t_ack[g][0] && t_ack[g][1], 1'b0);
         end
         if (c == 1) begin
            chk_b("grant_owner", 0, t_owner[0],    1'b0);
            chk_w("grant_addr",  0, t_mem_addr[0], 32'h10);
            chk_b("grant_wr",    0, t_mem_wr[0],   1'b0);
         end
         if (c == 2) begin
            chk_b("rd_ack0",  0, t_ack[0][0],   1'b1);
            chk_b("rd_ack1",  0, t_ack[0][1],   1'b0);
            chk_w("rd_data0", 0, t_rdata[0][0], 32'hDEADBEEF);
         end
         if (c <= 4) chk_w("lat3_addr_hold", 1, t_mem_addr[1], 32'h40);
         if (c == 3) chk_b("lat3_early_ack", 1, t_ack[1][0], 1'b0);
      end
      chk_w("svc_count", 0, 32'(nsv[0]), 32'd4);
      chk_w("svc_count", 1, 32'(nsv[1]), 32'd2);
      for (int k = 0; k < 4; k++) begin
         chk_w("svc_port",  0, (k < nsv[0]) ? 32'(ord[0][k]) : 32'hFF, 32'(k % 2));
         chk_w("svc_cycle", 0, (k < nsv[0]) ? 32'(at[0][k])  : 32'hFF, 32'(2 + 3 * k));
      end
      for (int k = 0; k < 2; k++) begin
         chk_w("svc_port",  1, (k < nsv[1]) ? 32'(ord[1][k]) : 32'hFF, 32'(k % 2));
         chk_w("svc_cycle", 1, (k < nsv[1]) ? 32'(at[1][k])  : 32'hFF, 32'(4 + 5 * k));
      end
      for (int g = 0; g < 2; g++) for (int p = 0; p < 2; p++) t_req[g][p] = 1'b0;
      repeat (8) step();

      // port 1 write on the MEM_LAT=1 instance
      t_we[0][1]    = 1'b1;
      t_addr[0][1]  = 32'h20;
      t_wdata[0][1] = 32'h12345678;
      t_req[0][1]   = 1'b1;
      nwr  = 0;
      nack = 0;
      for (int c = 1; c <= 6; c++) begin
         step();
         if (t_mem_wr[0]) begin
            nwr++;
            chk_w("wr_addr",  0, t_mem_addr[0],  32'h20);
            chk_w("wr_wdata", 0, t_mem_wdata[0], 32'h12345678);
         end
         if (t_ack[0][1]) begin
            nack++;
            t_req[0][1] = 1'b0;
         end
      end
      chk_w("wr_pulses",     0, 32'(nwr),  32'd1);
      chk_w("wr_acks",       0, 32'(nack), 32'd1);
      chk_w("wr_keep_rdata", 0, t_rdata[0][1], memf(32'h30));
      repeat (4) step();

      // MEM_LAT=3 write, reset in its second memory cycle, then full rerun
      t_we[1][0]    = 1'b1;
      t_addr[1][0]  = 32'h40;
      t_wdata[1][0] = 32'hA5A5A5A5;
      t_req[1][0]   = 1'b1;
      step();
      chk_b("lat3_wr_first", 1, t_mem_wr[1], 1'b1);
      step();
      chk_b("lat3_wr_second", 1, t_mem_wr[1], 1'b0);
      #2 reset = 1'b0;
      #1;
      chk_b("midrst_busy",   1, t_busy[1],     1'b0);
      chk_b("midrst_mem_wr", 1, t_mem_wr[1],   1'b0);
      chk_b("midrst_ack0",   1, t_ack[1][0],   1'b0);
      chk_w("midrst_addr",   1, t_mem_addr[1], 32'h0);
      step();
      reset = 1'b1;
      nwr   = 0;
      nack  = 0;
      ack_c = 0;
      for (int c = 1; c <= 8; c++) begin
         step();
         if (t_mem_wr[1]) nwr++;
         if (t_ack[1][0]) begin
            nack++;
            ack_c = c;
            t_req[1][0] = 1'b0;
         end
      end
      chk_w("rerun_wr_pulses", 1, 32'(nwr),   32'd1);
      chk_w("rerun_acks",      1, 32'(nack),  32'd1);
      chk_w("rerun_ack_cycle", 1, 32'(ack_c), 32'd4);
      repeat (4) step();

      // randomized traffic with occasional asynchronous resets
      repeat (4000) begin
         @(negedge clock);
         rand_drive();
         #2;
         if (!reset) reset = 1'b1;
         else if ($urandom_range(0, 299) == 0) reset = 1'b0;
      end
      @(negedge clock);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
